// File: rtl/pwm_gen.sv
// pwm_gen: sixteen-channel PWM generator sharing one 8-bit period counter
// and one duty value. Each channel is off, static-high or PWM-modulated.
// Optional build macro PWM_SHADOW_EN: when defined, the duty value is
// captured only at the period wrap, so mid-period changes never split a
// pulse. When undefined, the duty tracks the input every clock.
module pwm_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out,
  output logic        period_start
);

  // Last prescaler count before it wraps; PRESCALE=1 makes every cycle a tick.
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_act_q, duty_act_d;
  logic [15:0] pwm_out_q, pwm_out_d;
  logic        period_start_q, period_start_d;

  logic        tick;
  logic        wrap;
  logic        pwm_lvl;
  logic [15:0] eo;
  logic [15:0] ep;

  assign eo = {en_reg_out_15_8, en_reg_out_7_0};
  assign ep = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Next-state for counters, active duty and the per-channel output mux.
  always_comb begin
    tick      = (pre_cnt_q == PRE_LAST);
    wrap      = tick && (pwm_cnt_q == 8'hFF);
    pre_cnt_d = tick ? 16'd0 : (pre_cnt_q + 16'd1);
    pwm_cnt_d = tick ? (pwm_cnt_q + 8'd1) : pwm_cnt_q;
`ifdef PWM_SHADOW_EN
    // Shadowed duty: only the wrap edge may change what the pins see.
    duty_act_d = wrap ? pwm_duty_cycle : duty_act_q;
`else
    // Unshadowed duty: follow the input every clock.
    duty_act_d = pwm_duty_cycle;
`endif
    // 0xFF is forced fully high; otherwise high for counts below the duty.
    pwm_lvl = (duty_act_q == 8'hFF) || (pwm_cnt_q < duty_act_q);
    pwm_out_d = '0;
    for (int i = 0; i < 16; i++) begin
      // Output enable gates everything; PWM enable selects level vs. static high.
      pwm_out_d[i] = eo[i] & (~ep[i] | pwm_lvl);
    end
    period_start_d = wrap;
  end

  // All state clears immediately on reset, mid-period included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      duty_act_q     <= '0;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_act_q     <= duty_act_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;

endmodule
